// File: rtl/mdio_mgmt_arbiter.sv
// Round-robin arbiter that shares one Clause-22 MDIO bus among NUM_REQ requesters.
// Serialises one 64-bit frame per grant and returns read data / turnaround status.
module mdio_mgmt_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CLK_DIV = 40
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*5-1:0]    req_phy,
  input  logic [NUM_REQ*5-1:0]    req_reg,
  input  logic [NUM_REQ*16-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mdc,
  output logic                    mdio_out,
  output logic                    mdio_oe,
  input  logic                    mdio_in
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d, gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic [4:0]      phy_q, phy_d, reg_q, reg_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [DivW-1:0] div_q, div_d;
  logic            half_q, half_d;
  logic [5:0]      bit_q, bit_d, nxt_bit;
  logic            mdc_q, mdc_d, out_q, out_d, oe_q, oe_d;
  logic [15:0]     rd_sh_q, rd_sh_d, rdata_q, rdata_d;
  logic            ta_err_q, ta_err_d, err_q, err_d;
  logic [63:0]     frame;
  logic [NUM_REQ-1:0] ready_c;

  logic            found;
  logic [IdxW-1:0] pick;
  int unsigned     idx;

  // Frame as it appears on the wire, index 63 first; released bits of a read read back as 1.
  always_comb begin
    frame = {32'hFFFF_FFFF, 2'b01, (wr_q ? 2'b01 : 2'b10), phy_q, reg_q,
             (wr_q ? 2'b10 : 2'b11), (wr_q ? wdata_q : 16'hFFFF)};
  end

  // First pending requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    phy_d    = phy_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    div_d    = div_q;
    half_d   = half_q;
    bit_d    = bit_q;
    mdc_d    = mdc_q;
    out_d    = out_q;
    oe_d     = oe_q;
    rd_sh_d  = rd_sh_q;
    ta_err_d = ta_err_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ready_c  = '0;
    rsp_valid = '0;
    nxt_bit  = bit_q + 6'd1;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          ready_c[pick] = 1'b1;
          gnt_d    = pick;
          ptr_d    = (pick == IdxLast) ? '0 : pick + IdxW'(1);
          wr_d     = req_write[pick];
          phy_d    = req_phy[5*int'(pick) +: 5];
          reg_d    = req_reg[5*int'(pick) +: 5];
          wdata_d  = req_wdata[16*int'(pick) +: 16];
          div_d    = '0;
          half_d   = 1'b0;
          bit_d    = '0;
          mdc_d    = 1'b0;
          out_d    = 1'b1;
          oe_d     = 1'b1;
          rd_sh_d  = '0;
          ta_err_d = 1'b0;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!half_q) begin
            // Last low-phase cycle: sample the pin just before mdc rises.
            half_d = 1'b1;
            mdc_d  = 1'b1;
            if (bit_q == 6'd47) ta_err_d = mdio_in;
            if (bit_q >= 6'd48) rd_sh_d = {rd_sh_q[14:0], mdio_in};
          end else begin
            half_d = 1'b0;
            mdc_d  = 1'b0;
            if (bit_q == 6'd63) begin
              out_d   = 1'b1;
              oe_d    = 1'b0;
              rdata_d = wr_q ? 16'h0000 : rd_sh_q;
              err_d   = wr_q ? 1'b0 : ta_err_q;
              state_d = StDone;
            end else begin
              bit_d = nxt_bit;
              out_d = frame[6'd63 - nxt_bit];
              oe_d  = wr_q || (nxt_bit < 6'd46);
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
        rsp_valid[gnt_q] = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      phy_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      div_q    <= '0;
      half_q   <= 1'b0;
      bit_q    <= '0;
      mdc_q    <= 1'b0;
      out_q    <= 1'b1;
      oe_q     <= 1'b0;
      rd_sh_q  <= '0;
      ta_err_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      phy_q    <= phy_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      div_q    <= div_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      mdc_q    <= mdc_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      rd_sh_q  <= rd_sh_d;
      ta_err_q <= ta_err_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // The accept pulse is combinational, so hold it low while reset is asserted.
  assign req_ready = ready_c & {NUM_REQ{~arst}};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q == StShift);
  assign mdc       = mdc_q;
  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;

endmodule

// File: tb/tb_mdio_mgmt_arbiter.sv
// Directed bench for mdio_mgmt_arbiter: frame capture, PHY read model and a response
// scoreboard filled at accept time and drained on rsp_valid.
module tb_mdio_mgmt_arbiter;
  localparam int D = 2;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic [N-1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [N*5-1:0]  req_phy, req_reg;
  logic [N*16-1:0] req_wdata;
  logic [15:0]   rsp_rdata;
  logic          rsp_err, busy, mdc, mdio_out, mdio_oe, mdio_in;

  typedef struct {int g; logic [15:0] rdata; logic err;} exp_t;
  exp_t sb[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [N-1:0] drop_mask = '0;
  logic [N-1:0] hook_mask = '0;
  int hook_on_bit = -1;
  int hook_off_bit = -1;

  mdio_mgmt_arbiter #(.NUM_REQ(N), .CLK_DIV(D)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe), .mdio_in(mdio_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input int g, input logic wr, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd);
    req_write[g] = wr;
    req_phy[5*g +: 5] = phy;
    req_reg[5*g +: 5] = ra;
    req_wdata[16*g +: 16] = wd;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input int max_wait, output int waited);
    int n = 0;
    while (req_ready === '0 && n < max_wait) begin
      step();
      n++;
    end
    chk("grant", req_ready, exp);
    waited = n;
  endtask

  // Called in the accept cycle; runs the frame through its DONE cycle (or the abort point).
  task automatic run_frame(input int g, input logic wr, input logic [15:0] exp_rdata,
                           input logic exp_err, input logic [15:0] phy_word, input logic phy_ta,
                           input bit check_bits, input logic [63:0] exp_out,
                           input logic [63:0] exp_oe, input int abort_bit);
    logic [63:0] cap_out = '0;
    logic [63:0] cap_oe = '0;
    logic [3:0] bad = '0;
    logic [N-1:0] ev;
    exp_t e;
    int k, p;
    sb.push_back('{g: g, rdata: exp_rdata, err: exp_err});
    for (int c = 1; c <= 128*D; c++) begin
      step();
      if (c == 1) req_valid = req_valid & ~drop_mask;
      k = (c - 1) / (2*D);
      p = (c - 1) % (2*D);
      if (mdc !== (p >= D)) bad[0] = 1'b1;
      if (busy !== 1'b1) bad[1] = 1'b1;
      if (rsp_valid !== '0) bad[2] = 1'b1;
      if (req_ready !== '0) bad[3] = 1'b1;
      if (p == 0) begin
        cap_out[63-k] = mdio_out;
        cap_oe[63-k] = mdio_oe;
        if (k == abort_bit) begin
          arst = 1'b1;
          #1;
          chk("abort_outputs", {req_ready, rsp_valid, busy, mdc, mdio_out, mdio_oe},
              {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0});
          chk("abort_rsp", {rsp_rdata, rsp_err}, 17'h0);
          chk("abort_shift", bad, 4'b0);
          arst = 1'b0;
          void'(sb.pop_front());
          return;
        end
        if (!wr && k >= 46)
          mdio_in = (k == 46) ? 1'b1 : (k == 47) ? phy_ta : phy_word[63-k];
        if (k == hook_on_bit) req_valid = req_valid | hook_mask;
        if (k == hook_off_bit) req_valid = req_valid & ~hook_mask;
      end
    end
    step();
    mdio_in = 1'b1;
    e = sb.pop_front();
    ev = 4'b0001 << e.g;
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    chk("done_pins", {busy, mdc, mdio_oe, mdio_out}, 4'b0001);
    chk("shift_cycles", bad, 4'b0);
    if (check_bits) begin
      chk("frame_out", cap_out, exp_out);
      chk("frame_oe", cap_oe, exp_oe);
    end
  endtask

  initial begin
    int n, cnt;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [63:0] exp1, exp2, oe2;
    arst = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_phy = '0;
    req_reg = '0;
    req_wdata = '0;
    mdio_in = 1'b1;
    repeat (3) step();
    chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_out, mdio_oe},
        {4'b0, 4'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    arst = 1'b0;
    step();

    // Write to phy 1 reg 0.
    exp1 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
    set_req(0, 1'b1, 5'd1, 5'd0, 16'h1140);
    req_valid = 4'b0001;
    drop_mask = 4'b0001;
    #1;
    wait_grant(4'b0001, 5, n);
    chk("accept_latency", n, 0);
    run_frame(0, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1, exp1, {64{1'b1}}, -1);

    // Read from phy 3 reg 1, PHY answers 0x796D.
    exp2 = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd1, 2'b11, 16'hFFFF};
    oe2 = {{46{1'b1}}, {18{1'b0}}};
    set_req(2, 1'b0, 5'd3, 5'd1, 16'h0);
    req_valid = 4'b0100;
    drop_mask = 4'b0100;
    #1;
    wait_grant(4'b0100, 5, n);
    run_frame(2, 1'b0, 16'h796D, 1'b0, 16'h796D, 1'b0, 1, exp2, oe2, -1);
    step();
    chk("rdata_hold", {rsp_valid, rsp_rdata}, {4'b0, 16'h796D});

    // Read with no PHY: pin stays pulled high.
    set_req(3, 1'b0, 5'd5, 5'd2, 16'h0);
    req_valid = 4'b1000;
    drop_mask = 4'b1000;
    #1;
    wait_grant(4'b1000, 5, n);
    run_frame(3, 1'b0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, '0, '0, -1);

    // All requesters held: strict rotation, back-to-back grants.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i), 5'(i + 8), 16'hA000 + 16'(i));
    req_valid = 4'b1111;
    drop_mask = 4'b0000;
    #1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(4'b0001 << order[i], 300, n);
      if (i > 0) chk("rr_gap", n, 1);
      run_frame(order[i], 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 0, '0, '0, -1);
    end
    req_valid = 4'b1001;
    drop_mask = 4'b1000;
    #1;
    wait_grant(4'b1000, 5, n);
    run_frame(3, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 0, '0, '0, -1);
    drop_mask = 4'b0001;
    wait_grant(4'b0001, 5, n);
    run_frame(0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 0, '0, '0, -1);

    // Reset in the middle of a read: no response, pointer back to 0.
    set_req(2, 1'b0, 5'd7, 5'd3, 16'h0);
    req_valid = 4'b0100;
    drop_mask = 4'b0100;
    #1;
    wait_grant(4'b0100, 5, n);
    run_frame(2, 1'b0, 16'h0, 1'b0, 16'hFFFF, 1'b1, 0, '0, '0, 40);
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (rsp_valid !== '0 || busy !== 1'b0) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    set_req(1, 1'b1, 5'd4, 5'd9, 16'h55AA);
    set_req(3, 1'b1, 5'd6, 5'd9, 16'h1234);
    req_valid = 4'b1010;
    drop_mask = 4'b1010;
    #1;
    wait_grant(4'b0010, 5, n);
    run_frame(1, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 0, '0, '0, -1);

    // req1 comes and goes during another frame and is never served.
    set_req(0, 1'b1, 5'd2, 5'd4, 16'h0F0F);
    req_valid = 4'b0001;
    drop_mask = 4'b0001;
    hook_mask = 4'b0010;
    hook_on_bit = 10;
    hook_off_bit = 50;
    #1;
    wait_grant(4'b0001, 5, n);
    run_frame(0, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 0, '0, '0, -1);
    hook_on_bit = -1;
    hook_off_bit = -1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (req_ready !== '0 || busy !== 1'b0) cnt++;
    end
    chk("withdrawn_req", cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdio_mgmt_arbiter.md
Name: mdio_mgmt_arbiter

Overview:
Shares one Clause-22 MDIO management bus among NUM_REQ requesters, e.g. per-port PHY config agents and the CPU CSR path. It arbitrates round-robin, serialises one 64-bit MDIO frame per granted request, and returns read data or status to the winning requester. It sits between the control-plane logic and the board PHY MDC/MDIO pins, feeding the external tri-state buffer.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
CLK_DIV, 40, clk cycles per MDC half-period (>=1); default gives 2.5 MHz MDC from 200 MHz

Ports:
clk  input  1  system clock
arst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  request pending, per requester
req_ready  output  NUM_REQ  one-cycle accept pulse, per requester
req_write  input  NUM_REQ  1=write, 0=read
req_phy  input  NUM_REQ*5  PHY address, requester i at [5i+4:5i]
req_reg  input  NUM_REQ*5  register address, same packing
req_wdata  input  NUM_REQ*16  write data, requester i at [16i+15:16i]
rsp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  output  16  read data (0x0000 for writes); valid with rsp_valid
rsp_err  output  1  read turnaround error; valid with rsp_valid
busy  output  1  frame in progress
mdc  output  1  management clock
mdio_out  output  1  MDIO drive value
mdio_oe  output  1  MDIO drive enable
mdio_in  input  1  MDIO pin sample

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, mdc=0, mdio_out=1, mdio_oe=0. The round-robin pointer resets to 0.
- States:
  - IDLE: if any req_valid, grant the first set requester at or after the pointer (wrapping). Pulse req_ready[g] this cycle, latch the request fields, set the pointer to g+1 mod NUM_REQ, go to SHIFT.
  - SHIFT: busy=1. Send 64 bits. Each bit is CLK_DIV cycles with mdc=0, then CLK_DIV cycles with mdc=1. mdio_out/oe change only on the first low-phase cycle of each bit.
  - DONE: one cycle. rsp_valid[g]=1, busy=0. Next cycle is IDLE.
- Latency: if acceptance is cycle 0, SHIFT runs cycles 1..128*CLK_DIV and rsp_valid fires at cycle 128*CLK_DIV+1. The earliest next req_ready is the cycle after rsp_valid.
- Frame bit order (index 0 first):
  - bits 0-31: preamble of 1s
  - bits 32-33: ST = 01
  - bits 34-35: OP = 01 for write, 10 for read
  - bits 36-40: PHY address, MSB first
  - bits 41-45: register address, MSB first
  - bits 46-47: TA
  - bits 48-63: data, MSB first
- Write: mdio_oe=1 for bits 0-63; TA = 1,0; data = wdata.
- Read:
  - mdio_oe=1 for bits 0-45, 0 for bits 46-63; mdio_out=1 while released.
  - mdio_in is sampled on the last low-phase cycle of each bit (the cycle before the mdc rise).
  - TA bit 47 sampled as 1 sets rsp_err=1. Data is still captured, so an absent PHY yields 0xFFFF.
- After DONE: mdc=0, mdio_oe=0, mdio_out=1.
- A request deasserted before its req_ready is never granted. No request is accepted while busy; valids hold until accepted. Changing a requester's fields while its valid is held and not yet accepted is allowed; fields are sampled only in the accept cycle.
- rsp_rdata/rsp_err hold their values until the next DONE.
- arst mid-frame immediately forces reset values. No rsp_valid is issued for the aborted request, and the requester must re-request.

Test Plan:
- CLK_DIV=2, req0 write, phy=1, reg=0, wdata=0x1140 → req_ready[0] at cycle 0. Captured mdio_out over 64 bits = 32×1, 01, 01, 00001, 00000, 10, 0001000101000000; mdio_oe=1 throughout. rsp_valid[0] at cycle 257, rsp_rdata=0x0000, rsp_err=0.
- req2 read, phy=3, reg=1, PHY model drives TA 0 then 0x796D → mdio_oe falls at bit 46. rsp_valid[2] only, rsp_rdata=0x796D, rsp_err=0.
- Read with mdio_in held 1 (no PHY) → rsp_err=1, rsp_rdata=0xFFFF.
- All 4 valids held continuously → grants in order 0,1,2,3,0. Then pointer=1 with only req0 and req3 valid → grant 3 then 0.
- arst pulse at bit 40 of a read → outputs return to reset values at once, no rsp_valid, pointer=0. A new req1 afterwards is granted and completes normally.
- req1 valid asserted during another frame, then deasserted before DONE → never granted; busy drops after DONE.
